// File: rtl/cpu_ctrl_pkg.sv
// Shared types and widths for the Y86 host run controller.
package cpu_ctrl_pkg;

  localparam int WORD_W     = 64;
  localparam int ADDR_W     = 64;
  localparam int BYTE_W     = 8;
  localparam int STAT_W     = 4;
  localparam int REG_ADDR_W = 4;

  localparam logic [STAT_W-1:0] STAT_AOK = 4'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 4'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 4'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STEP,
    S_HALTED,
    S_DUMP
  } ctrl_state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Valid/ready byte or word stream with a last marker; used for program load and register dump.
interface cpu_run_ctrl_if #(parameter int W = 8);
  logic         valid;
  logic         ready;
  logic         last;
  logic [W-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/ctrl_loader.sv
// Program load path: accepts bytes while active and issues one registered imem write per byte.
module ctrl_loader
  import cpu_ctrl_pkg::*;
#(
  parameter int I_MEM_DEPTH = 1024
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                active,
  cpu_run_ctrl_if.slave       load,
  output logic                done,
  output logic                wr_en,
  output logic [BYTE_W-1:0]   wr_data,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic                ovf
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(I_MEM_DEPTH);

  logic              fire;
  logic              in_range;
  logic [ADDR_W-1:0] ptr_reg;

  assign load.ready = active;
  assign fire       = active & load.valid;
  assign in_range   = (ptr_reg < DEPTH);
  assign done       = fire & load.last;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      wr_addr <= '0;
      ovf     <= 1'b0;
    end else begin
      // Out-of-range bytes are still consumed so the host stream never stalls.
      wr_en <= fire & in_range;
      if (fire) begin
        wr_data <= load.data;
        wr_addr <= ptr_reg;
      end
      if (start) begin
        ptr_reg <= '0;
        ovf     <= 1'b0;
      end else if (fire) begin
        ptr_reg <= ptr_reg + ADDR_W'(1);
        if (!in_range) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host run controller: program load, run/step gating with cycle limit, halt capture and register dump.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int I_MEM_DEPTH = 1024,
  parameter int NUM_REGS    = 15,
  parameter int MAX_CYCLES  = 1000000
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  cmd_load,
  input  logic                  cmd_run,
  input  logic                  cmd_step,
  input  logic                  cmd_dump,
  input  logic                  cmd_abort,
  cpu_run_ctrl_if.slave         load,
  cpu_run_ctrl_if.master        dump,
  input  logic [STAT_W-1:0]     cpu_status,
  input  logic [WORD_W-1:0]     reg_val_debug,
  output logic                  cpu_valid,
  output logic                  debug,
  output logic [REG_ADDR_W-1:0] reg_addr_debug,
  output logic                  imem_wr_en,
  output logic [BYTE_W-1:0]     imem_wr_data,
  output logic [ADDR_W-1:0]     imem_wr_addr,
  output logic [WORD_W-1:0]     cycle_cnt,
  output logic [STAT_W-1:0]     final_status,
  output logic                  timeout,
  output logic                  load_ovf,
  output logic                  busy
);

  localparam logic [WORD_W-1:0]     LIMIT    = WORD_W'(MAX_CYCLES);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  ctrl_state_e           state_reg, state_next;
  logic [REG_ADDR_W-1:0] idx_reg;
  logic                  load_start, run_start, dump_start;
  logic                  load_active, load_done;
  logic                  run_en, status_bad, limit_hit, dump_fire;

  assign run_en     = (state_reg == S_RUN) || (state_reg == S_STEP);
  assign status_bad = (cpu_status != STAT_AOK);
  assign limit_hit  = (MAX_CYCLES != 0) && ((cycle_cnt + WORD_W'(1)) == LIMIT);
  assign dump_fire  = (state_reg == S_DUMP) && dump.ready;

  ctrl_loader #(.I_MEM_DEPTH(I_MEM_DEPTH)) u_loader (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .start   (load_start),
    .active  (load_active),
    .load    (load),
    .done    (load_done),
    .wr_en   (imem_wr_en),
    .wr_data (imem_wr_data),
    .wr_addr (imem_wr_addr),
    .ovf     (load_ovf)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_start = 1'b0;
    run_start  = 1'b0;
    dump_start = 1'b0;
    if (cmd_abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_load)      begin state_next = S_LOAD; load_start = 1'b1; end
          else if (cmd_run)  begin state_next = S_RUN;  run_start  = 1'b1; end
          else if (cmd_step) begin state_next = S_STEP; end
          else if (cmd_dump) begin state_next = S_DUMP; dump_start = 1'b1; end
        end
        S_LOAD:   if (load_done) state_next = S_IDLE;
        S_RUN:    if (status_bad || limit_hit) state_next = S_HALTED;
        S_STEP:   state_next = status_bad ? S_HALTED : S_IDLE;
        // The core needs a reset after halting, so only load and dump leave here.
        S_HALTED: begin
          if (cmd_load)      begin state_next = S_LOAD; load_start = 1'b1; end
          else if (cmd_dump) begin state_next = S_DUMP; dump_start = 1'b1; end
        end
        S_DUMP:   if (dump_fire && idx_reg == LAST_IDX) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_valid      = run_en & ~status_bad & ~cmd_abort;
    debug          = (state_reg == S_DUMP);
    reg_addr_debug = debug ? idx_reg : '0;
    dump.valid     = debug;
    dump.data      = debug ? reg_val_debug : '0;
    dump.last      = debug && (idx_reg == LAST_IDX);
    load_active    = (state_reg == S_LOAD);
    busy           = (state_reg != S_IDLE) && (state_reg != S_HALTED);
  end

  // Steps accumulate into cycle_cnt so a single-step session counts its instructions; a run restarts it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt    <= '0;
      final_status <= STAT_AOK;
      timeout      <= 1'b0;
      idx_reg      <= '0;
    end else begin
      if (run_start)      cycle_cnt <= '0;
      else if (cpu_valid) cycle_cnt <= cycle_cnt + WORD_W'(1);

      if (run_start) timeout <= 1'b0;
      else if (state_reg == S_RUN && state_next == S_HALTED && !status_bad) timeout <= 1'b1;

      // On a limit stop the status is AOK, so latching it directly covers both exits.
      if (state_reg != S_HALTED && state_next == S_HALTED) final_status <= cpu_status;

      if (dump_start)     idx_reg <= '0;
      else if (dump_fire) idx_reg <= idx_reg + REG_ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: load, run/halt, cycle limit, steps, dump and abort/overflow.
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        cmd_load, cmd_run, cmd_step, cmd_dump, cmd_abort;
  logic [3:0]  cpu_status;
  logic [63:0] reg_val_debug;
  logic        cpu_valid, debug, imem_wr_en, timeout, load_ovf, busy;
  logic [3:0]  reg_addr_debug, final_status;
  logic [7:0]  imem_wr_data;
  logic [63:0] imem_wr_addr, cycle_cnt;

  cpu_run_ctrl_if #(.W(8))  load_bus ();
  cpu_run_ctrl_if #(.W(64)) dump_bus ();

  cpu_run_ctrl #(.I_MEM_DEPTH(1024), .NUM_REGS(15), .MAX_CYCLES(16)) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .cmd_load       (cmd_load),
    .cmd_run        (cmd_run),
    .cmd_step       (cmd_step),
    .cmd_dump       (cmd_dump),
    .cmd_abort      (cmd_abort),
    .load           (load_bus),
    .dump           (dump_bus),
    .cpu_status     (cpu_status),
    .reg_val_debug  (reg_val_debug),
    .cpu_valid      (cpu_valid),
    .debug          (debug),
    .reg_addr_debug (reg_addr_debug),
    .imem_wr_en     (imem_wr_en),
    .imem_wr_data   (imem_wr_data),
    .imem_wr_addr   (imem_wr_addr),
    .cycle_cnt      (cycle_cnt),
    .final_status   (final_status),
    .timeout        (timeout),
    .load_ovf       (load_ovf),
    .busy           (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Core debug port model: register i reads as a distinct pattern.
  function automatic logic [63:0] reg_pattern(input logic [63:0] i);
    return 64'h0101_0101_0101_0101 * i + 64'hDEAD_0000_0000_0000;
  endfunction
  assign reg_val_debug = reg_pattern({60'd0, reg_addr_debug});

  int n_compared = 0;
  int n_mismatched = 0;
  int wr_count = 0;
  int wr_high = 0;

  always @(posedge sys_clk) begin
    if (rst_n && imem_wr_en) begin
      wr_count++;
      if (imem_wr_addr >= 64'd1024) wr_high++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  logic [7:0] prog [11] = '{8'h30, 8'hF0, 8'h05, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    int commits;
    int idx_exp;
    rst_n = 1'b0;
    cmd_load = 0; cmd_run = 0; cmd_step = 0; cmd_dump = 0; cmd_abort = 0;
    cpu_status = STAT_AOK;
    load_bus.valid = 0; load_bus.data = 0; load_bus.last = 0;
    dump_bus.ready = 0;
    #12;
    check_eq("rst_outputs", {cpu_valid, debug, busy, timeout, load_ovf, imem_wr_en,
                             load_bus.ready, dump_bus.valid}, 8'h00);
    check_eq("rst_final_status", final_status, STAT_AOK);
    check_eq("rst_cycle_cnt", cycle_cnt, 0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    tick();

    // Program load: writes trail each handshake by one cycle.
    cmd_load = 1; tick(); cmd_load = 0; #1;
    check_eq("load_ready", {load_bus.ready, busy}, 2'b11);
    for (int i = 0; i < 11; i++) begin
      load_bus.valid = 1; load_bus.data = prog[i]; load_bus.last = (i == 10);
      #1;
      if (i == 0) check_eq("load_wr_latency", imem_wr_en, 0);
      tick();
      check_eq($sformatf("load_wr%0d", i), {imem_wr_en, imem_wr_addr[15:0], imem_wr_data},
               {1'b1, 16'(i), prog[i]});
    end
    load_bus.valid = 0; load_bus.last = 0; #1;
    check_eq("load_done_idle", {load_bus.ready, busy}, 2'b00);
    tick();
    check_eq("load_wr_stop", imem_wr_en, 0);

    // Run to halt on cycle 7.
    cmd_run = 1; tick(); cmd_run = 0;
    for (int c = 1; c <= 7; c++) begin
      cpu_status = (c == 7) ? STAT_HLT : STAT_AOK;
      #1;
      check_eq($sformatf("run_valid_c%0d", c), cpu_valid, (c != 7));
      tick();
    end
    check_eq("run_cycle_cnt", cycle_cnt, 6);
    check_eq("run_final_status", final_status, STAT_HLT);
    check_eq("run_halted_busy", busy, 0);

    // Cycle limit on an endless loop.
    cpu_status = STAT_AOK;
    cmd_abort = 1; tick(); cmd_abort = 0;
    cmd_run = 1; tick(); cmd_run = 0;
    commits = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (cpu_valid) commits++;
      tick();
    end
    check_eq("limit_commits", commits, 16);
    check_eq("limit_cycle_cnt", cycle_cnt, 16);
    check_eq("limit_timeout", timeout, 1);
    check_eq("limit_final_status", final_status, STAT_AOK);
    check_eq("limit_busy", busy, 0);

    // Async reset mid-run clears everything at once.
    cmd_abort = 1; tick(); cmd_abort = 0;
    cmd_run = 1; tick(); cmd_run = 0;
    tick(); tick(); tick();
    rst_n = 1'b0; #1;
    check_eq("arst_clear", {cpu_valid, busy, timeout}, 3'b000);
    check_eq("arst_cycle_cnt", cycle_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single steps accumulate, a faulting step halts, run is then ignored.
    for (int s = 1; s <= 3; s++) begin
      cmd_step = 1; tick(); cmd_step = 0; #1;
      check_eq($sformatf("step%0d_valid", s), cpu_valid, 1);
      tick();
      check_eq($sformatf("step%0d_after", s), {cpu_valid, busy}, 2'b00);
      check_eq($sformatf("step%0d_cnt", s), cycle_cnt, s);
    end
    cmd_step = 1; tick(); cmd_step = 0;
    cpu_status = STAT_ADR; #1;
    check_eq("step_fault_valid", cpu_valid, 0);
    tick();
    cpu_status = STAT_AOK;
    check_eq("step_fault_status", final_status, STAT_ADR);
    cmd_run = 1; tick(); cmd_run = 0; #1;
    check_eq("halted_run_ignored", {cpu_valid, busy}, 2'b00);
    check_eq("halted_cycle_cnt", cycle_cnt, 3);

    // Register dump with out_ready toggling.
    cmd_dump = 1; tick(); cmd_dump = 0;
    idx_exp = 0;
    for (int c = 0; c < 60 && idx_exp < 15; c++) begin
      dump_bus.ready = (c % 2 == 0);
      #1;
      check_eq($sformatf("dump_c%0d_valid", c), {dump_bus.valid, debug}, 2'b11);
      check_eq($sformatf("dump_c%0d_addr", c), reg_addr_debug, idx_exp);
      check_eq($sformatf("dump_c%0d_data", c), dump_bus.data, reg_pattern(64'(idx_exp)));
      check_eq($sformatf("dump_c%0d_last", c), dump_bus.last, (idx_exp == 14));
      if (dump_bus.ready) idx_exp++;
      tick();
    end
    dump_bus.ready = 0; #1;
    check_eq("dump_done", {dump_bus.valid, debug, busy}, 3'b000);

    // Abort mid-run.
    cmd_run = 1; tick(); cmd_run = 0;
    tick(); tick();
    cmd_abort = 1; #1;
    check_eq("abort_run_valid", cpu_valid, 0);
    tick(); cmd_abort = 0; #1;
    check_eq("abort_run_idle", {cpu_valid, busy}, 2'b00);
    check_eq("abort_run_cnt", cycle_cnt, 2);

    // Abort mid-load.
    cmd_load = 1; tick(); cmd_load = 0;
    for (int i = 0; i < 3; i++) begin
      load_bus.valid = 1; load_bus.data = 8'(i); load_bus.last = 0;
      tick();
    end
    load_bus.valid = 0;
    cmd_abort = 1; tick(); cmd_abort = 0; #1;
    check_eq("abort_load_idle", {load_bus.ready, busy}, 2'b00);
    tick(); tick();

    // Oversized load: 1030 bytes into 1024-byte memory.
    wr_count = 0; wr_high = 0;
    cmd_load = 1; tick(); cmd_load = 0;
    for (int i = 0; i < 1030; i++) begin
      load_bus.valid = 1; load_bus.data = 8'(i); load_bus.last = (i == 1029);
      tick();
      if (i == 1023) check_eq("ovf_at_1023", load_ovf, 0);
      if (i == 1024) check_eq("ovf_at_1024", load_ovf, 1);
    end
    load_bus.valid = 0; load_bus.last = 0;
    tick(); tick();
    check_eq("ovf_sticky", load_ovf, 1);
    check_eq("ovf_wr_count", wr_count, 1024);
    check_eq("ovf_wr_high", wr_high, 0);
    check_eq("ovf_idle", busy, 0);
    cmd_load = 1; tick(); cmd_load = 0; #1;
    check_eq("ovf_clear_on_load", {load_ovf, load_bus.ready}, 2'b01);
    cmd_abort = 1; tick(); cmd_abort = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
